// File: rtl/fp_div_pack_if.sv
// Handshake bundle between the SRT iteration unit, the divide back end and the result port.
// The divide back end uses the slave modport; the upstream/downstream side uses master.
interface fp_div_pack_if #(
  parameter int QW     = 27,
  parameter int EXP_IW = 10
);
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_sign;
  logic signed [EXP_IW-1:0] in_exp;
  logic [QW-1:0]            in_quot;
  logic                     in_rem_nz;
  logic [1:0]               in_special;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_result;
  logic                     out_overflow;
  logic                     out_underflow;
  logic                     out_inexact;

  modport master (
    output in_valid, in_sign, in_exp, in_quot, in_rem_nz, in_special, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_quot, in_rem_nz, in_special, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
  );
endinterface

// File: rtl/fp_div_pack.sv
// FP32 divide back end: normalizes the SRT quotient (S1), then rounds to nearest-even,
// detects overflow/underflow and packs the IEEE-754 result (S2). Valid/ready on both sides.
module fp_div_pack #(
  parameter int QW     = 27,
  parameter int EXP_IW = 10
) (
  input  logic          clk,
  input  logic          rst,
  fp_div_pack_if.slave  bus
);
  localparam int EW = EXP_IW + 1;

  localparam logic [1:0] SP_ZERO = 2'b01;
  localparam logic [1:0] SP_INF  = 2'b10;
  localparam logic [1:0] SP_NAN  = 2'b11;

  localparam logic signed [EW-1:0] EXP_OVF  = EW'(255);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);

  // Handshake state
  logic ready_q;
  logic s1_valid_q;
  logic out_valid_q;
  logic s2_adv;
  logic s1_adv;
  logic in_fire;

  // Stage 1 (normalized operand)
  logic                 s1_sign_q;
  logic [1:0]           s1_special_q;
  logic signed [EW-1:0] s1_exp_q,  s1_exp_d;
  logic [22:0]          s1_mant_q, s1_mant_d;
  logic [2:0]           s1_grs_q,  s1_grs_d;
  logic signed [EW-1:0] exp_ext;

  // Stage 2 (packed result)
  logic [31:0]          out_result_q,    out_result_d;
  logic                 out_overflow_q,  out_overflow_d;
  logic                 out_underflow_q, out_underflow_d;
  logic                 out_inexact_q,   out_inexact_d;
  logic                 round_inc;
  logic [23:0]          mant_sum;
  logic signed [EW-1:0] exp_r;

  assign s2_adv  = !out_valid_q || bus.out_ready;
  assign s1_adv  = !s1_valid_q || s2_adv;
  assign in_fire = bus.in_valid && ready_q && s1_adv;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path infers a latch.
    exp_ext   = {bus.in_exp[EXP_IW-1], bus.in_exp};
    s1_mant_d = bus.in_quot[QW-2 -: 23];
    s1_grs_d  = {bus.in_quot[QW-25], bus.in_quot[QW-26],
                 (|bus.in_quot[QW-27:0]) | bus.in_rem_nz};
    s1_exp_d  = exp_ext;
    // Quotient below 1.0: shift left one place and compensate in the exponent.
    if (!bus.in_quot[QW-1]) begin
      s1_mant_d = bus.in_quot[QW-3 -: 23];
      s1_grs_d  = {bus.in_quot[QW-26], bus.in_quot[QW-27], bus.in_rem_nz};
      s1_exp_d  = exp_ext - EXP_ONE;
    end
  end

  always_comb begin
    round_inc = s1_grs_q[2] & (s1_grs_q[1] | s1_grs_q[0] | s1_mant_q[0]);
    mant_sum  = {1'b0, s1_mant_q} + {23'd0, round_inc};
    // A carry out leaves mant_sum[22:0] at zero, which is exactly the renormalized mantissa.
    exp_r     = s1_exp_q + {{(EW-1){1'b0}}, mant_sum[23]};

    out_result_d    = {s1_sign_q, exp_r[7:0], mant_sum[22:0]};
    out_overflow_d  = 1'b0;
    out_underflow_d = 1'b0;
    out_inexact_d   = |s1_grs_q;

    if (exp_r >= EXP_OVF) begin
      out_result_d   = {s1_sign_q, 8'hFF, 23'h0};
      out_overflow_d = 1'b1;
      out_inexact_d  = 1'b1;
    end else if (exp_r <= EXP_ZERO) begin
      out_result_d    = {s1_sign_q, 31'h0};
      out_underflow_d = 1'b1;
      out_inexact_d   = 1'b1;
    end

    if (s1_special_q != 2'b00) begin
      out_overflow_d  = 1'b0;
      out_underflow_d = 1'b0;
      out_inexact_d   = 1'b0;
      case (s1_special_q)
        SP_ZERO: out_result_d = {s1_sign_q, 31'h0};
        SP_INF:  out_result_d = {s1_sign_q, 8'hFF, 23'h0};
        SP_NAN:  out_result_d = 32'h7FC0_0000;
        default: out_result_d = {s1_sign_q, 31'h0};
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q         <= 1'b0;
      s1_valid_q      <= 1'b0;
      s1_sign_q       <= 1'b0;
      s1_special_q    <= 2'b00;
      s1_exp_q        <= '0;
      s1_mant_q       <= '0;
      s1_grs_q        <= '0;
      out_valid_q     <= 1'b0;
      out_result_q    <= '0;
      out_overflow_q  <= 1'b0;
      out_underflow_q <= 1'b0;
      out_inexact_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates let S2 capture S1's pre-edge contents in the same edge.
      ready_q <= 1'b1;
      if (s1_adv) begin
        s1_valid_q <= in_fire;
        if (in_fire) begin
          s1_sign_q    <= bus.in_sign;
          s1_special_q <= bus.in_special;
          s1_exp_q     <= s1_exp_d;
          s1_mant_q    <= s1_mant_d;
          s1_grs_q     <= s1_grs_d;
        end
      end
      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_result_q    <= out_result_d;
          out_overflow_q  <= out_overflow_d;
          out_underflow_q <= out_underflow_d;
          out_inexact_q   <= out_inexact_d;
        end
      end
    end
  end

  assign bus.in_ready      = ready_q && s1_adv;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_result    = out_result_q;
  assign bus.out_overflow  = out_overflow_q;
  assign bus.out_underflow = out_underflow_q;
  assign bus.out_inexact   = out_inexact_q;
endmodule
